// File: rtl/fluxo_dados_jogo_memoria_pkg.sv
// Shared constants and types for the sequence-memory game datapath.
// Holds the default sizes, the button edge-detector states and the RAM boot image.
package fluxo_dados_jogo_memoria_pkg;

    localparam int DATA_W         = 4;
    localparam int ADDR_W         = 4;
    localparam int TIMEOUT_CYCLES = 5000;
    localparam int SHOW_CYCLES    = 1000;

    typedef enum logic {
        SOLTO       = 1'b0,
        PRESSIONADO = 1'b1
    } estado_botao_t;

    // Boot image of the sequence RAM: only word 0 holds a colour at power-up.
    function automatic logic [DATA_W-1:0] imagem_inicial(input int endereco);
        return (endereco == 0) ? DATA_W'(1) : '0;
    endfunction

endpackage

// File: rtl/fluxo_dados_jogo_memoria_if.sv
// Command/status bundle between the game control unit (master) and the datapath (slave).
// The raw player buttons travel with it because the datapath samples them alongside the commands.
interface fluxo_dados_jogo_memoria_if #(
    parameter int DATA_W = fluxo_dados_jogo_memoria_pkg::DATA_W,
    parameter int ADDR_W = fluxo_dados_jogo_memoria_pkg::ADDR_W
);
    logic [DATA_W-1:0] botoes;
    logic              zeraE, contaE, zeraRod, contaRod;
    logic              zeraT, contaT, zeraP, contaP;
    logic              zeraR, registraR, we, sinal_led;

    logic              fimE, fimRod, fimT, fimP;
    logic              jogada, igual, enderecoIgualRodada;
    logic [DATA_W-1:0] leds, db_memoria, db_jogada;
    logic [ADDR_W-1:0] db_endereco, db_rodada;

    modport master (
        output botoes, zeraE, contaE, zeraRod, contaRod, zeraT, contaT,
               zeraP, contaP, zeraR, registraR, we, sinal_led,
        input  fimE, fimRod, fimT, fimP, jogada, igual, enderecoIgualRodada,
               leds, db_memoria, db_jogada, db_endereco, db_rodada
    );

    modport slave (
        input  botoes, zeraE, contaE, zeraRod, contaRod, zeraT, contaT,
               zeraP, contaP, zeraR, registraR, we, sinal_led,
        output fimE, fimRod, fimT, fimP, jogada, igual, enderecoIgualRodada,
               leds, db_memoria, db_jogada, db_endereco, db_rodada
    );

endinterface

// File: rtl/fluxo_dados_jogo_memoria_contador.sv
// Generic modulo-M counter with clear priority over increment.
// SATURA=1 makes it stop at M-1 instead of wrapping back to 0.
module contador_modulo_m #(
    parameter int M      = 16,
    parameter int N      = 4,
    parameter bit SATURA = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera_i,
    input  logic         conta_i,
    output logic [N-1:0] q_o,
    output logic         fim_o
);

    localparam logic [N-1:0] ULTIMO = N'(M - 1);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (zera_i) begin
            q_d = '0;
        end else if (conta_i) begin
            if (q_q == ULTIMO) begin
                q_d = SATURA ? ULTIMO : '0;
            end else begin
                q_d = q_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o   = q_q;
    assign fim_o = (q_q == ULTIMO);

endmodule

// File: rtl/fluxo_dados_jogo_memoria.sv
// Datapath of the sequence-memory game: sequence RAM, four counters, play register
// and the button edge detector, all driven by the control unit through the slave modport.
module fluxo_dados_jogo_memoria #(
    parameter int DATA_W         = fluxo_dados_jogo_memoria_pkg::DATA_W,
    parameter int ADDR_W         = fluxo_dados_jogo_memoria_pkg::ADDR_W,
    parameter int TIMEOUT_CYCLES = fluxo_dados_jogo_memoria_pkg::TIMEOUT_CYCLES,
    parameter int SHOW_CYCLES    = fluxo_dados_jogo_memoria_pkg::SHOW_CYCLES
) (
    input  logic                        clock,
    input  logic                        reset,
    fluxo_dados_jogo_memoria_if.slave   bus
);
    import fluxo_dados_jogo_memoria_pkg::*;

    localparam int PROFUNDIDADE = 2 ** ADDR_W;
    localparam int T_W          = $clog2(TIMEOUT_CYCLES);
    localparam int P_W          = $clog2(SHOW_CYCLES);

    logic [ADDR_W-1:0] endereco, rodada;
    logic [T_W-1:0]    contagemT;
    logic [P_W-1:0]    contagemP;
    logic              unusedContagens;

    contador_modulo_m #(.M(PROFUNDIDADE), .N(ADDR_W), .SATURA(1'b0)) contadorE (
        .clock(clock), .reset(reset), .zera_i(bus.zeraE), .conta_i(bus.contaE),
        .q_o(endereco), .fim_o(bus.fimE)
    );

    contador_modulo_m #(.M(PROFUNDIDADE), .N(ADDR_W), .SATURA(1'b0)) contadorRod (
        .clock(clock), .reset(reset), .zera_i(bus.zeraRod), .conta_i(bus.contaRod),
        .q_o(rodada), .fim_o(bus.fimRod)
    );

    contador_modulo_m #(.M(TIMEOUT_CYCLES), .N(T_W), .SATURA(1'b1)) contadorT (
        .clock(clock), .reset(reset), .zera_i(bus.zeraT), .conta_i(bus.contaT),
        .q_o(contagemT), .fim_o(bus.fimT)
    );

    contador_modulo_m #(.M(SHOW_CYCLES), .N(P_W), .SATURA(1'b1)) contadorP (
        .clock(clock), .reset(reset), .zera_i(bus.zeraP), .conta_i(bus.contaP),
        .q_o(contagemP), .fim_o(bus.fimP)
    );

    assign unusedContagens = ^{contagemT, contagemP};

    logic [DATA_W-1:0] reg_q, reg_d;

    always_comb begin
        reg_d = reg_q;
        if (bus.zeraR) begin
            reg_d = '0;
        end else if (bus.registraR) begin
            reg_d = bus.botoes;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    // Storage cells power up cleared and are never reset, so each word is kept
    // XOR-ed with its boot-image value; that gives RAM[0]=0001 out of power-up.
    logic [DATA_W-1:0] mem_q [PROFUNDIDADE];
    logic [DATA_W-1:0] imagemAtual;
    logic [DATA_W-1:0] leituraMem;

    assign imagemAtual = DATA_W'(imagem_inicial(int'(endereco)));
    assign leituraMem  = mem_q[endereco] ^ imagemAtual;

    always_ff @(posedge clock) begin
        if (bus.we && reset) begin
            mem_q[endereco] <= reg_q ^ imagemAtual;
        end
    end

    estado_botao_t estado_q;
    logic          jogada_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= SOLTO;
            jogada_q <= 1'b0;
        end else begin
            jogada_q <= 1'b0;
            case (estado_q)
                SOLTO: begin
                    if (|bus.botoes) begin
                        estado_q <= PRESSIONADO;
                        jogada_q <= 1'b1;
                    end
                end
                PRESSIONADO: begin
                    if (!(|bus.botoes)) begin
                        estado_q <= SOLTO;
                    end
                end
                default: estado_q <= SOLTO;
            endcase
        end
    end

    assign bus.jogada              = jogada_q;
    assign bus.igual               = (leituraMem == reg_q);
    assign bus.enderecoIgualRodada = (endereco == rodada);
    assign bus.leds                = bus.sinal_led ? leituraMem : bus.botoes;
    assign bus.db_endereco         = endereco;
    assign bus.db_rodada           = rodada;
    assign bus.db_memoria          = leituraMem;
    assign bus.db_jogada           = reg_q;

endmodule

// File: tb/tb_fluxo_dados_jogo_memoria.sv
// Self-checking bench for the game datapath: a cycle model built from the game rules
// is compared with every output each cycle, plus hand-computed spot values.
module tb_fluxo_dados_jogo_memoria;
    import fluxo_dados_jogo_memoria_pkg::*;

    localparam int PROF     = 2 ** ADDR_W;
    localparam int ULTIMO_T = TIMEOUT_CYCLES - 1;
    localparam int ULTIMO_P = SHOW_CYCLES - 1;

    typedef struct packed {
        logic [DATA_W-1:0] botoes;
        logic zeraE, contaE, zeraRod, contaRod, zeraT, contaT;
        logic zeraP, contaP, zeraR, registraR, we, sinal_led;
    } cmd_t;

    localparam cmd_t IDLE = '0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   compareOn = 1'b0;

    fluxo_dados_jogo_memoria_if bus ();

    fluxo_dados_jogo_memoria dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int mE, mRod, mT, mP, mR;
    int mRam [PROF];
    bit mPrevAny, mAny, mJogada;

    initial begin
        foreach (mRam[i]) mRam[i] = 0;
        mRam[0] = 1;
    end

    // Rules-level model: a press is "buttons now, none last cycle"; RAM writes use pre-edge values.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mE = 0; mRod = 0; mT = 0; mP = 0; mR = 0;
            mPrevAny = 1'b0; mJogada = 1'b0;
        end else begin
            mAny = (bus.botoes != 0);
            if (bus.we) mRam[mE] = mR;
            mJogada  = mAny && !mPrevAny;
            mPrevAny = mAny;
            mE   = bus.zeraE   ? 0 : (bus.contaE   ? (mE + 1) % PROF   : mE);
            mRod = bus.zeraRod ? 0 : (bus.contaRod ? (mRod + 1) % PROF : mRod);
            mT   = bus.zeraT   ? 0 : (bus.contaT && mT < ULTIMO_T ? mT + 1 : mT);
            mP   = bus.zeraP   ? 0 : (bus.contaP && mP < ULTIMO_P ? mP + 1 : mP);
            mR   = bus.zeraR   ? 0 : (bus.registraR ? int'(bus.botoes) : mR);
        end
    end

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    always begin
        @(posedge clock);
        #1;
        if (compareOn) begin
            checkOutput("fimE",   32'(bus.fimE),   32'(mE == PROF - 1));
            checkOutput("fimRod", 32'(bus.fimRod), 32'(mRod == PROF - 1));
            checkOutput("fimT",   32'(bus.fimT),   32'(mT == ULTIMO_T));
            checkOutput("fimP",   32'(bus.fimP),   32'(mP == ULTIMO_P));
            checkOutput("jogada", 32'(bus.jogada), 32'(mJogada));
            checkOutput("igual",  32'(bus.igual),  32'(mRam[mE] == mR));
            checkOutput("endIgualRod", 32'(bus.enderecoIgualRodada), 32'(mE == mRod));
            checkOutput("leds", 32'(bus.leds), bus.sinal_led ? 32'(mRam[mE]) : 32'(bus.botoes));
            checkOutput("db_endereco", 32'(bus.db_endereco), 32'(mE));
            checkOutput("db_rodada",   32'(bus.db_rodada),   32'(mRod));
            checkOutput("db_memoria",  32'(bus.db_memoria),  32'(mRam[mE]));
            checkOutput("db_jogada",   32'(bus.db_jogada),   32'(mR));
        end
    end

    task automatic driveCmd(input cmd_t c);
        bus.botoes    = c.botoes;
        bus.zeraE     = c.zeraE;     bus.contaE   = c.contaE;
        bus.zeraRod   = c.zeraRod;   bus.contaRod = c.contaRod;
        bus.zeraT     = c.zeraT;     bus.contaT   = c.contaT;
        bus.zeraP     = c.zeraP;     bus.contaP   = c.contaP;
        bus.zeraR     = c.zeraR;     bus.registraR = c.registraR;
        bus.we        = c.we;        bus.sinal_led = c.sinal_led;
    endtask

    // Holds the command for n clock edges and returns just after the last edge.
    task automatic applyStimulus(input cmd_t c, input int n);
        repeat (n) begin
            @(negedge clock);
            driveCmd(c);
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        cmd_t c;
        driveCmd(IDLE);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        compareOn = 1'b1;
        checkOutput("rst_endereco", 32'(bus.db_endereco), 32'd0);
        checkOutput("rst_endIgualRod", 32'(bus.enderecoIgualRodada), 32'd1);
        checkOutput("rst_igual", 32'(bus.igual), 32'd0);
        checkOutput("rst_jogada", 32'(bus.jogada), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        c = IDLE; c.sinal_led = 1'b1;
        applyStimulus(c, 1);
        checkOutput("leds_ram0", 32'(bus.leds), 32'd1);
        c = IDLE; c.botoes = 4'b1000;
        applyStimulus(c, 1);
        checkOutput("leds_botoes", 32'(bus.leds), 32'd8);
        applyStimulus(IDLE, 1);

        c = IDLE; c.contaE = 1'b1; c.contaT = 1'b1;
        applyStimulus(c, 5);
        c.contaE = 1'b0;
        applyStimulus(c, 295);
        checkOutput("pre_rst_E", 32'(bus.db_endereco), 32'd5);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("midrst_E", 32'(bus.db_endereco), 32'd0);
        checkOutput("midrst_fimT", 32'(bus.fimT), 32'd0);
        checkOutput("midrst_endIgual", 32'(bus.enderecoIgualRodada), 32'd1);
        checkOutput("midrst_jogada", 32'(bus.jogada), 32'd0);
        driveCmd(IDLE);
        @(negedge clock);
        reset = 1'b1;

        c = IDLE; c.contaE = 1'b1;
        applyStimulus(c, 15);
        checkOutput("E_15", 32'(bus.db_endereco), 32'd15);
        checkOutput("fimE_15", 32'(bus.fimE), 32'd1);
        applyStimulus(c, 1);
        checkOutput("E_wrap", 32'(bus.db_endereco), 32'd0);
        checkOutput("fimE_wrap", 32'(bus.fimE), 32'd0);
        applyStimulus(c, 3);
        c.zeraE = 1'b1;
        applyStimulus(c, 1);
        checkOutput("E_zera_prio", 32'(bus.db_endereco), 32'd0);

        c = IDLE; c.contaT = 1'b1;
        applyStimulus(c, ULTIMO_T - 1);
        checkOutput("fimT_early", 32'(bus.fimT), 32'd0);
        applyStimulus(c, 1);
        checkOutput("fimT_rise", 32'(bus.fimT), 32'd1);
        applyStimulus(c, 3);
        checkOutput("fimT_sat", 32'(bus.fimT), 32'd1);
        c = IDLE; c.zeraT = 1'b1;
        applyStimulus(c, 1);
        checkOutput("fimT_zera", 32'(bus.fimT), 32'd0);

        c = IDLE; c.contaP = 1'b1;
        applyStimulus(c, ULTIMO_P - 1);
        checkOutput("fimP_early", 32'(bus.fimP), 32'd0);
        applyStimulus(c, 1);
        checkOutput("fimP_rise", 32'(bus.fimP), 32'd1);
        applyStimulus(c, 5);
        checkOutput("fimP_sat", 32'(bus.fimP), 32'd1);
        c.zeraP = 1'b1;
        applyStimulus(c, 1);
        checkOutput("fimP_zera", 32'(bus.fimP), 32'd0);

        c = IDLE; c.botoes = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(c, 1);
            checkOutput("jogada_hold", 32'(bus.jogada), 32'(i == 0));
        end
        applyStimulus(IDLE, 2);
        checkOutput("jogada_solto", 32'(bus.jogada), 32'd0);
        applyStimulus(c, 1);
        checkOutput("jogada_repress", 32'(bus.jogada), 32'd1);
        c.botoes = 4'b0100;
        applyStimulus(c, 1);
        checkOutput("jogada_troca", 32'(bus.jogada), 32'd0);
        applyStimulus(IDLE, 1);

        c = IDLE; c.botoes = 4'b0100; c.registraR = 1'b1;
        applyStimulus(c, 1);
        checkOutput("R_0100", 32'(bus.db_jogada), 32'd4);
        c = IDLE; c.contaE = 1'b1;
        applyStimulus(c, 1);
        checkOutput("ram1_antes", 32'(bus.db_memoria), 32'd0);
        c = IDLE; c.we = 1'b1;
        @(negedge clock);
        driveCmd(c);
        #1;
        checkOutput("ram1_leitura_velha", 32'(bus.db_memoria), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("ram1_escrita", 32'(bus.db_memoria), 32'd4);
        checkOutput("igual_E1", 32'(bus.igual), 32'd1);
        c = IDLE; c.zeraE = 1'b1;
        applyStimulus(c, 1);
        checkOutput("igual_E0", 32'(bus.igual), 32'd0);
        c = IDLE; c.contaE = 1'b1;
        applyStimulus(c, 1);
        checkOutput("igual_volta", 32'(bus.igual), 32'd1);
        c = IDLE; c.botoes = 4'b0001; c.registraR = 1'b1;
        applyStimulus(c, 1);
        checkOutput("igual_R0001", 32'(bus.igual), 32'd0);
        c = IDLE; c.zeraR = 1'b1; c.registraR = 1'b1; c.botoes = 4'b0001;
        applyStimulus(c, 1);
        checkOutput("zeraR_prio", 32'(bus.db_jogada), 32'd0);
        applyStimulus(IDLE, 1);

        c = IDLE; c.zeraE = 1'b1; c.contaRod = 1'b1;
        applyStimulus(c, 1);
        checkOutput("endIgual_0_1", 32'(bus.enderecoIgualRodada), 32'd0);
        c = IDLE; c.contaE = 1'b1;
        applyStimulus(c, 1);
        checkOutput("endIgual_1_1", 32'(bus.enderecoIgualRodada), 32'd1);
        c = IDLE; c.contaRod = 1'b1;
        applyStimulus(c, 14);
        checkOutput("fimRod_15", 32'(bus.fimRod), 32'd1);

        c = IDLE; c.botoes = 4'b0010; c.registraR = 1'b1;
        applyStimulus(c, 1);
        applyStimulus(IDLE, 1);
        c = IDLE; c.we = 1'b1;
        @(negedge clock);
        driveCmd(c);
        reset = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        driveCmd(IDLE);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rst_write_E", 32'(bus.db_endereco), 32'd0);
        checkOutput("rst_write_ram0", 32'(bus.db_memoria), 32'd1);
        c = IDLE; c.contaE = 1'b1;
        applyStimulus(c, 1);
        checkOutput("rst_write_ram1", 32'(bus.db_memoria), 32'd4);
        applyStimulus(IDLE, 2);

        compareOn = 1'b0;
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
